// File: rtl/lfsr_seq_ctrl_if.sv
// Control/status bundle between host logic, the LFSR sequencer and the
// LFSR + sample-RAM datapath.
interface lfsr_seq_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int LFSR_W = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_len;
  logic [LFSR_W-1:0] cfg_seed;
  logic              mem_rdy;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              lfsr_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, cfg_len, cfg_seed, mem_rdy,
    input  lfsr_load, lfsr_seed, lfsr_en, mem_we, mem_addr, busy, done, err
  );

  modport slave (
    input  start, abort, cfg_len, cfg_seed, mem_rdy,
    output lfsr_load, lfsr_seed, lfsr_en, mem_we, mem_addr, busy, done, err
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// LFSR test-pattern sequencer: seeds the LFSR, then steps it once per accepted
// sample write while generating sequential sample-RAM addresses.
module lfsr_seq_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int LFSR_W  = 16,
  parameter int DEF_LEN = 12282
) (
  input  logic clk,
  input  logic rst_n,
  lfsr_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] DEF_LEN_W = ADDR_W'(DEF_LEN);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LFSR_W-1:0] seed_q;
  logic              err_q;
  logic              accept;
  logic              last;
  logic              take_start;
  logic              bad_start;

  assign take_start    = (state == S_IDLE) && bus.start && (bus.cfg_seed != '0);
  assign bad_start     = (state == S_IDLE) && bus.start && (bus.cfg_seed == '0);
  assign bus.mem_addr  = addr_q;
  assign bus.lfsr_seed = seed_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Strobes are a pure decode of state (and mem_rdy in RUN), so they drop to
  // zero the instant reset asserts.
  always_comb begin
    state_nx      = state;
    bus.lfsr_load = 1'b0;
    bus.lfsr_en   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    accept        = 1'b0;
    last          = 1'b0;
    case (state)
      S_IDLE: begin
        if (take_start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        bus.lfsr_load = 1'b1;
        bus.busy      = 1'b1;
        state_nx      = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        bus.busy    = 1'b1;
        accept      = bus.mem_rdy;
        bus.lfsr_en = accept;
        bus.mem_we  = accept;
        last        = accept && (addr_q == len_q - ONE);
        if (bus.abort)  state_nx = S_IDLE;
        else if (last)  state_nx = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      seed_q <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= bad_start;
      if (take_start) begin
        len_q  <= (bus.cfg_len == '0) ? DEF_LEN_W : bus.cfg_len;
        seed_q <= bus.cfg_seed;
        addr_q <= '0;
      end else if (accept && !last) begin
        // Final write leaves the address parked on len_q-1.
        addr_q <= addr_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: stimulus predicts the event stream of each
// run (load, writes, done/err with cycle stamps); a negedge monitor consumes it.
module tb_lfsr_seq_ctrl;

  localparam int ADDR_W  = 14;
  localparam int LFSR_W  = 16;
  localparam int DEF_LEN = 12282;

  localparam int EV_LOAD = 0;
  localparam int EV_WR   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int          kind;
    int unsigned addr;
    int unsigned seed;
    int unsigned cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  logic        exp_busy = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_seq_ctrl_if #(.ADDR_W(ADDR_W), .LFSR_W(LFSR_W)) bus ();

  lfsr_seq_ctrl #(.ADDR_W(ADDR_W), .LFSR_W(LFSR_W), .DEF_LEN(DEF_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic string kname(input int k);
    case (k)
      EV_LOAD: return "load";
      EV_WR:   return "write";
      EV_DONE: return "done";
      default: return "err";
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int unsigned addr, input int unsigned seed,
                      input int unsigned c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.seed = seed; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic consume(input int kind, input int unsigned addr, input int unsigned seed);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s @cyc %0d: got strobe, expected none", kname(kind), cyc);
    end else begin
      e = sb.pop_front();
      check({"kind_", kname(e.kind)}, 64'(kind), 64'(e.kind));
      check({"cycle_", kname(e.kind)}, 64'(cyc), 64'(e.cyc));
      if (kind == EV_WR || kind == EV_DONE) check({"addr_", kname(kind)}, 64'(addr), 64'(e.addr));
      if (kind == EV_LOAD) check("seed_load", 64'(seed), 64'(e.seed));
    end
  endtask

  // Monitor: independent of the stimulus; pops whenever the DUT strobes.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("lfsr_en_eq_mem_we", 64'(bus.lfsr_en), 64'(bus.mem_we));
      check("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.lfsr_load) consume(EV_LOAD, 0, 32'(bus.lfsr_seed));
      if (bus.mem_we)    consume(EV_WR, 32'(bus.mem_addr), 0);
      if (bus.done)      consume(EV_DONE, 32'(bus.mem_addr), 0);
      if (bus.err)       consume(EV_ERR, 0, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
    check("rst_lfsr_seed", 64'(bus.lfsr_seed), 64'(0));
    check("rst_mem_we",    64'(bus.mem_we),    64'(0));
    check("rst_lfsr_en",   64'(bus.lfsr_en),   64'(0));
    check("rst_lfsr_load", 64'(bus.lfsr_load), 64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    check("rst_err",       64'(bus.err),       64'(0));
  endtask

  // mode: 0 mem_rdy always 1, 1 pattern 1,0,0, 2 random.
  // stop: 0 none, 1 abort on write number stop_at, 2 async reset before write stop_at.
  task automatic run(input int unsigned len_cfg, input logic [LFSR_W-1:0] seed, input int mode,
                     input int stop, input int unsigned stop_at, input bit noise);
    int unsigned t0, n, w, phase;
    logic [31:0] lv;
    bit rdy;
    step();
    lv = len_cfg;
    bus.cfg_len  = lv[ADDR_W-1:0];
    bus.cfg_seed = seed;
    bus.start    = 1'b1;
    bus.abort    = 1'($urandom_range(0, 1));
    bus.mem_rdy  = 1'($urandom_range(0, 1));
    exp_busy     = 1'b0;
    t0 = cyc;
    if (seed == '0) begin
      push(EV_ERR, 0, 0, t0 + 1);
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      return;
    end
    n = (len_cfg == 0) ? DEF_LEN : len_cfg;
    push(EV_LOAD, 0, 32'(seed), t0 + 1);
    step();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.mem_rdy = 1'($urandom_range(0, 1));
    exp_busy    = 1'b1;
    w = 0;
    phase = 0;
    while (w < n) begin
      step();
      bus.cfg_len  = ADDR_W'($urandom);
      bus.cfg_seed = LFSR_W'($urandom);
      if (noise) bus.start = 1'($urandom_range(0, 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (stop == 2 && w == stop_at) begin
        bus.mem_rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_busy = 1'b0;
        #1;
        check_reset_values();
        step();
        rst_n = 1'b1;
        return;
      end
      bus.mem_rdy = rdy;
      if (rdy) begin
        push(EV_WR, w, 0, cyc);
        w++;
      end
      if (stop == 1 && rdy && w == stop_at) begin
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        exp_busy  = 1'b0;
        return;
      end
    end
    step();
    bus.start   = 1'b0;
    bus.mem_rdy = 1'($urandom_range(0, 1));
    exp_busy    = 1'b0;
    push(EV_DONE, n - 1, 0, cyc);
  endtask

  task automatic drain(input string name);
    repeat (3) begin
      step();
      bus.mem_rdy = 1'($urandom_range(0, 1));
      bus.abort   = 1'($urandom_range(0, 1));
    end
    bus.abort = 1'b0;
    check({"pending_", name}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.cfg_len  = '0;
    bus.cfg_seed = '0;
    bus.mem_rdy  = 1'b1;
    repeat (3) step();
    check_reset_values();
    rst_n = 1'b1;
    step();

    run(0, 16'hACE1, 0, 0, 0, 1'b0);               drain("default_len");
    run(5, 16'h1234, 1, 0, 0, 1'b0);               drain("len5_stall");
    run(7, 16'h0000, 0, 0, 0, 1'b0);               drain("zero_seed");
    run(100, 16'hBEEF, 2, 1, 40, 1'b0);            drain("abort40");
    run(20, 16'h0F0F, 0, 0, 0, 1'b0);              drain("after_abort");
    run(30, 16'h5A5A, 2, 0, 0, 1'b1);              drain("start_noise");
    run(1, 16'h0001, 0, 0, 0, 1'b0);               drain("len1");
    run(50, 16'hC001, 0, 2, 10, 1'b0);             drain("reset_mid");
    run(8, 16'h7777, 2, 0, 0, 1'b0);               drain("after_reset");
    run(16383, 16'hFFFF, 0, 0, 0, 1'b0);           drain("max_len");
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 60), LFSR_W'($urandom_range(1, 65535)),
          int'($urandom_range(0, 2)), 0, 0, 1'($urandom_range(0, 1)));
      drain("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
